// File: rtl/imx_sync_framer_pkg.sv
// Sync-code words and framer state encoding for the IMX LVDS path,
// shared with the pattern generator and capture blocks.
package imx_sync_pkg;

    localparam logic [9:0] SYNC0       = 10'h3FF;
    localparam logic [9:0] SYNC1       = 10'h000;
    localparam logic [9:0] SYNC2       = 10'h000;
    localparam logic [9:0] SAV_VALID   = 10'h200;
    localparam logic [9:0] SAV_INVALID = 10'h2AC;
    localparam logic [9:0] EAV_VALID   = 10'h274;
    localparam logic [9:0] EAV_INVALID = 10'h2D8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEEK,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_ACTIVE,
        ST_BLANK,
        ST_E1,
        ST_E2,
        ST_E3
    } state_t;

endpackage

// File: rtl/imx_sync_framer_if.sv
// Word stream in from the deserializer and the pixel/strobe
// bundle out to the capture path.
interface imx_sync_framer_if #(
    parameter int COL_WIDTH = 12,
    parameter int ROW_WIDTH = 12
);
    logic [9:0]           i_data;
    logic                 i_data_valid;
    logic [9:0]           o_pix_data;
    logic                 o_pix_valid;
    logic                 o_line_start;
    logic                 o_line_end;
    logic                 o_frame_start;
    logic                 o_frame_end;
    logic [COL_WIDTH-1:0] o_col;
    logic [ROW_WIDTH-1:0] o_row;

    modport master (
        output i_data, i_data_valid,
        input  o_pix_data, o_pix_valid,
        input  o_line_start, o_line_end,
        input  o_frame_start, o_frame_end,
        input  o_col, o_row
    );

    modport slave (
        input  i_data, i_data_valid,
        output o_pix_data, o_pix_valid,
        output o_line_start, o_line_end,
        output o_frame_start, o_frame_end,
        output o_col, o_row
    );

endinterface

// File: rtl/imx_sync_framer_sat_counter.sv
// Saturating event counter with synchronous clear;
// clear takes priority over a same-cycle increment.
module imx_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imx_sync_framer.sv
// Sync-code parser and active-pixel gate for one IMX LVDS lane,
// with line/frame strobes, position tracking and error counters.
module imx_sync_framer
    import imx_sync_pkg::*;
#(
    parameter int COL_WIDTH     = 12,
    parameter int ROW_WIDTH     = 12,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     camera_clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    input  logic [COL_WIDTH-1:0]     i_line_width,
    input  logic                     i_clear_errors,
    output logic                     o_busy,
    output logic [ERR_CNT_WIDTH-1:0] o_format_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] o_width_err_cnt,
    imx_sync_framer_if.slave         bus
);

    state_t               state, state_n;
    logic [COL_WIDTH-1:0] col, col_n;
    logic [COL_WIDTH-1:0] col_out, col_out_n;
    logic [ROW_WIDTH-1:0] row, row_n;
    logic                 in_frame, in_frame_n;
    logic                 first, first_n;
    logic                 act, act_n;
    logic [9:0]           pix_data, pix_data_n;
    logic                 pix_valid, pix_valid_n;
    logic                 line_start, line_start_n;
    logic                 line_end, line_end_n;
    logic                 frame_start, frame_start_n;
    logic                 frame_end, frame_end_n;
    logic                 busy;
    logic                 fmt_inc, wid_inc;
    logic [9:0]           word;
    logic                 dv;

    assign word = bus.i_data;
    assign dv   = bus.i_data_valid;

    always_comb begin
        state_n       = state;
        col_n         = col;
        row_n         = row;
        in_frame_n    = in_frame;
        first_n       = first;
        act_n         = act;
        col_out_n     = col_out;
        pix_data_n    = '0;
        pix_valid_n   = 1'b0;
        line_start_n  = 1'b0;
        line_end_n    = 1'b0;
        frame_start_n = 1'b0;
        frame_end_n   = 1'b0;
        fmt_inc       = 1'b0;
        wid_inc       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_enable) state_n = ST_SEEK;
            end
            ST_SEEK: begin
                if (!i_enable) state_n = ST_IDLE;
                else if (dv && word == SYNC0) state_n = ST_S1;
            end
            ST_S1: begin
                if (!i_enable) begin
                    state_n = ST_IDLE;
                end else if (dv) begin
                    if (word == SYNC1) begin
                        state_n = ST_S2;
                    end else begin
                        fmt_inc = 1'b1;
                        state_n = ST_SEEK;
                    end
                end
            end
            ST_S2: begin
                if (!i_enable) begin
                    state_n = ST_IDLE;
                end else if (dv) begin
                    state_n = ST_S3;
                    if (word != SYNC2) begin
                        fmt_inc = 1'b1;
                        // a fresh 3FF may be the start of the real sequence
                        state_n = (word == SYNC0) ? ST_S1 : ST_SEEK;
                    end
                end
            end
            ST_S3: begin
                if (!i_enable) begin
                    state_n = ST_IDLE;
                end else if (dv) begin
                    unique case (1'b1)
                        (word == SAV_VALID): begin
                            state_n = ST_ACTIVE;
                            col_n   = '0;
                            first_n = 1'b1;
                            act_n   = 1'b1;
                        end
                        (word == SAV_INVALID): begin
                            state_n     = ST_BLANK;
                            act_n       = 1'b0;
                            frame_end_n = in_frame;
                            in_frame_n  = 1'b0;
                        end
                        default: begin
                            fmt_inc = 1'b1;
                            state_n = ST_SEEK;
                        end
                    endcase
                end
            end
            ST_ACTIVE: begin
                if (dv && word == SYNC0) begin
                    state_n = ST_E1;
                end else if (dv) begin
                    pix_valid_n = 1'b1;
                    pix_data_n  = word;
                    col_out_n   = col;
                    if (col != '1) col_n = col + 1'b1;
                    if (first) begin
                        line_start_n = 1'b1;
                        first_n      = 1'b0;
                        if (!in_frame) begin
                            frame_start_n = 1'b1;
                            in_frame_n    = 1'b1;
                            row_n         = '0;
                        end
                    end
                end
            end
            ST_BLANK: begin
                if (dv && word == SYNC0) state_n = ST_E1;
            end
            ST_E1, ST_E2: begin
                if (dv) begin
                    if (word == SYNC1) begin
                        state_n = (state == ST_E1) ? ST_E2 : ST_E3;
                    end else begin
                        fmt_inc = 1'b1;
                        state_n = ST_SEEK;
                    end
                end
            end
            ST_E3: begin
                if (dv) begin
                    state_n = i_enable ? ST_SEEK : ST_IDLE;
                    if (act && word == EAV_VALID) begin
                        line_end_n = 1'b1;
                        row_n      = row + 1'b1;
                        wid_inc    = (col != i_line_width);
                    end else if (act || word != EAV_INVALID) begin
                        fmt_inc = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge camera_clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            col         <= '0;
            col_out     <= '0;
            row         <= '0;
            in_frame    <= 1'b0;
            first       <= 1'b0;
            act         <= 1'b0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            col_out     <= col_out_n;
            row         <= row_n;
            in_frame    <= in_frame_n;
            first       <= first_n;
            act         <= act_n;
            pix_data    <= pix_data_n;
            pix_valid   <= pix_valid_n;
            line_start  <= line_start_n;
            line_end    <= line_end_n;
            frame_start <= frame_start_n;
            frame_end   <= frame_end_n;
            busy        <= (state_n != ST_IDLE);
        end
    end

    imx_sat_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_fmt_cnt (
        .clk   (camera_clk),
        .rst_n (rst_n),
        .clear (i_clear_errors),
        .inc   (fmt_inc),
        .count (o_format_err_cnt)
    );

    imx_sat_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_wid_cnt (
        .clk   (camera_clk),
        .rst_n (rst_n),
        .clear (i_clear_errors),
        .inc   (wid_inc),
        .count (o_width_err_cnt)
    );

    assign o_busy            = busy;
    assign bus.o_pix_data    = pix_data;
    assign bus.o_pix_valid   = pix_valid;
    assign bus.o_line_start  = line_start;
    assign bus.o_line_end    = line_end;
    assign bus.o_frame_start = frame_start;
    assign bus.o_frame_end   = frame_end;
    assign bus.o_col         = col_out;
    assign bus.o_row         = row;

endmodule

// File: tb/tb_imx_sync_framer.sv
// Scoreboard bench for imx_sync_framer: line-level stimulus with
// expected strobes/pixels queued and checked by an output monitor.
module tb_imx_sync_framer;
    import imx_sync_pkg::*;

    localparam int CW = 12;
    localparam int RW = 12;
    localparam int EW = 16;

    logic          camera_clk = 1'b0;
    logic          rst_n;
    logic          i_enable;
    logic [CW-1:0] i_line_width;
    logic          i_clear_errors;
    logic          o_busy;
    logic [EW-1:0] o_format_err_cnt;
    logic [EW-1:0] o_width_err_cnt;

    imx_sync_framer_if #(.COL_WIDTH(CW), .ROW_WIDTH(RW)) bus ();

    imx_sync_framer #(
        .COL_WIDTH     (CW),
        .ROW_WIDTH     (RW),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .camera_clk       (camera_clk),
        .rst_n            (rst_n),
        .i_enable         (i_enable),
        .i_line_width     (i_line_width),
        .i_clear_errors   (i_clear_errors),
        .o_busy           (o_busy),
        .o_format_err_cnt (o_format_err_cnt),
        .o_width_err_cnt  (o_width_err_cnt),
        .bus              (bus)
    );

    always #5 camera_clk = ~camera_clk;

    typedef struct packed {
        logic          pv;
        logic          ls;
        logic          fs;
        logic          le;
        logic          fe;
        logic [9:0]    data;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
    } ev_t;

    ev_t           exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    bit            in_frame_m = 0;
    logic [RW-1:0] row_m = '0;
    int            fmt_m = 0;
    int            wid_m = 0;
    int            gap_pct = 0;
    bit            gearbox = 0;
    int            gb_cnt = 0;

    // Output monitor: every strobe or pixel must match the queue head
    always @(negedge camera_clk) begin
        ev_t a;
        ev_t e;
        if (bus.o_pix_valid || bus.o_line_start || bus.o_line_end ||
            bus.o_frame_start || bus.o_frame_end) begin
            a.pv   = bus.o_pix_valid;
            a.ls   = bus.o_line_start;
            a.fs   = bus.o_frame_start;
            a.le   = bus.o_line_end;
            a.fe   = bus.o_frame_end;
            a.data = a.pv ? bus.o_pix_data : '0;
            a.col  = a.pv ? bus.o_col : '0;
            a.row  = a.pv ? bus.o_row : '0;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got pv=%b ls=%b fs=%b le=%b fe=%b, expected no event",
                         a.pv, a.ls, a.fs, a.le, a.fe);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL event: got pv=%b ls=%b fs=%b le=%b fe=%b data=%h col=%0d row=%0d, expected pv=%b ls=%b fs=%b le=%b fe=%b data=%h col=%0d row=%0d",
                             a.pv, a.ls, a.fs, a.le, a.fe, a.data, a.col, a.row,
                             e.pv, e.ls, e.fs, e.le, e.fe, e.data, e.col, e.row);
                end
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic idle_cycle();
        @(negedge camera_clk);
        bus.i_data_valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] w);
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
        @(negedge camera_clk);
        bus.i_data       = w;
        bus.i_data_valid = 1'b1;
        if (gearbox) begin
            gb_cnt++;
            if (gb_cnt % 4 == 0) idle_cycle();
        end
    endtask

    task automatic send_sync(input logic [9:0] code);
        send_word(SYNC0);
        send_word(SYNC1);
        send_word(SYNC2);
        send_word(code);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) send_word(10'($urandom_range(0, 511)));
    endtask

    task automatic pixels(input int n);
        ev_t        e;
        logic [9:0] px;
        for (int i = 0; i < n; i++) begin
            px     = 10'($urandom_range(0, 511));
            e      = '0;
            e.pv   = 1'b1;
            e.data = px;
            e.col  = CW'(i);
            if (i == 0) begin
                e.ls = 1'b1;
                if (!in_frame_m) begin
                    e.fs       = 1'b1;
                    in_frame_m = 1'b1;
                    row_m      = '0;
                end
            end
            e.row = row_m;
            exp_q.push_back(e);
            send_word(px);
        end
    endtask

    task automatic valid_line(input int n, input bit bad_eav);
        ev_t e;
        send_sync(SAV_VALID);
        pixels(n);
        send_word(SYNC0);
        send_word(SYNC1);
        if (bad_eav) begin
            send_word(EAV_INVALID);
            fmt_m++;
        end else begin
            e    = '0;
            e.le = 1'b1;
            exp_q.push_back(e);
            send_word(SYNC2);
            send_word(EAV_VALID);
            row_m++;
            if (n != int'(i_line_width)) wid_m++;
        end
    endtask

    task automatic blank_line(input int n);
        ev_t e;
        if (in_frame_m) begin
            e          = '0;
            e.fe       = 1'b1;
            in_frame_m = 1'b0;
            exp_q.push_back(e);
        end
        send_sync(SAV_INVALID);
        fill(n);
        send_sync(EAV_INVALID);
    endtask

    task automatic bad_sav_line(input int n);
        send_word(SYNC0);
        send_word(SYNC1);
        send_word(SYNC2);
        fill(n);
        fmt_m++;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        idle_cycle();
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge camera_clk);
            t++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge camera_clk);
    endtask

    task automatic check_cnts(input string name);
        check({name, "_format_err"}, o_format_err_cnt, fmt_m);
        check({name, "_width_err"}, o_width_err_cnt, wid_m);
    endtask

    initial begin
        int         t;
        int         n;
        logic [9:0] px;
        rst_n            = 1'b0;
        i_enable         = 1'b0;
        i_line_width     = CW'(256);
        i_clear_errors   = 1'b0;
        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        repeat (3) @(negedge camera_clk);
        check("reset_busy", o_busy, 0);
        check("reset_pix_valid", bus.o_pix_valid, 0);
        check("reset_col", bus.o_col, 0);
        check("reset_row", bus.o_row, 0);
        check_cnts("reset");

        rst_n    = 1'b1;
        i_enable = 1'b1;
        repeat (2) @(negedge camera_clk);
        check("enable_busy", o_busy, 1);

        // blanking then a 12-line frame
        for (int i = 0; i < 8; i++) blank_line(256);
        for (int i = 0; i < 12; i++) valid_line(256, 0);
        drain("frame");
        check_cnts("frame");

        // same traffic through a 4-of-5 gearbox
        gearbox = 1;
        for (int i = 0; i < 2; i++) blank_line(256);
        for (int i = 0; i < 12; i++) valid_line(256, 0);
        drain("gearbox");
        check_cnts("gearbox");
        gearbox = 0;

        bad_sav_line(20);
        valid_line(256, 0);
        drain("bad_sav");
        check_cnts("bad_sav");

        valid_line(256, 1);
        valid_line(256, 0);
        drain("bad_eav");
        check_cnts("bad_eav");

        valid_line(250, 0);
        drain("short_line");
        check_cnts("short_line");

        // clear coincides with a format error on the missing code word
        send_word(SYNC0);
        send_word(SYNC1);
        send_word(SYNC2);
        send_word(10'h005);
        i_clear_errors = 1'b1;
        idle_cycle();
        i_clear_errors = 1'b0;
        fmt_m = 0;
        wid_m = 0;
        @(negedge camera_clk);
        check_cnts("clear");

        // randomized line mix with gearbox-style gaps
        i_line_width = CW'(24);
        gap_pct = 20;
        for (int k = 0; k < 120; k++) begin
            t = int'($urandom_range(0, 9));
            n = ($urandom_range(0, 1) != 0) ? 24 : int'($urandom_range(1, 40));
            if (t < 5) valid_line(n, 0);
            else if (t < 7) blank_line(int'($urandom_range(1, 40)));
            else if (t < 8) bad_sav_line(int'($urandom_range(1, 40)));
            else valid_line(n, 1);
        end
        drain("random");
        check_cnts("random");
        gap_pct = 0;

        // drop enable mid-line: line still completes, then idle
        i_line_width = CW'(256);
        send_sync(SAV_VALID);
        pixels(100);
        i_enable = 1'b0;
        for (int i = 100; i < 256; i++) begin
            ev_t e;
            px     = 10'($urandom_range(0, 511));
            e      = '0;
            e.pv   = 1'b1;
            e.data = px;
            e.col  = CW'(i);
            e.row  = row_m;
            exp_q.push_back(e);
            send_word(px);
        end
        begin
            ev_t e;
            e    = '0;
            e.le = 1'b1;
            exp_q.push_back(e);
        end
        send_sync(EAV_VALID);
        row_m++;
        drain("disable");
        check("disable_busy", o_busy, 0);
        send_sync(SAV_VALID);
        fill(10);
        send_sync(EAV_VALID);
        drain("ignored");
        check("ignored_busy", o_busy, 0);
        check_cnts("disable");

        // reset in the middle of an active line
        i_enable = 1'b1;
        repeat (2) @(negedge camera_clk);
        bad_sav_line(5);
        send_sync(SAV_VALID);
        pixels(50);
        drain("pre_reset");
        check_cnts("pre_reset");
        @(negedge camera_clk);
        bus.i_data       = 10'h011;
        bus.i_data_valid = 1'b1;
        rst_n            = 1'b0;
        @(negedge camera_clk);
        check("midreset_pix_valid", bus.o_pix_valid, 0);
        check("midreset_pix_data", bus.o_pix_data, 0);
        check("midreset_col", bus.o_col, 0);
        check("midreset_row", bus.o_row, 0);
        check("midreset_busy", o_busy, 0);
        check("midreset_format_err", o_format_err_cnt, 0);
        bus.i_data_valid = 1'b0;
        rst_n            = 1'b1;
        in_frame_m       = 1'b0;
        row_m            = '0;
        fmt_m            = 0;
        wid_m            = 0;
        repeat (2) @(negedge camera_clk);
        i_line_width = CW'(24);
        valid_line(24, 0);
        valid_line(24, 0);
        drain("post_reset");
        check_cnts("post_reset");
        check("final_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
